// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding and the R/W bit values,
// usable by both the slave and any master-side logic.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ACK_ADDR  = 3'd2,
      ST_SUB       = 3'd3,
      ST_ACK_SUB   = 3'd4,
      ST_DATA      = 3'd5,
      ST_ACK_DATA  = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the CLOCK domain and produces single-cycle
// SCL edge, START and STOP pulses from the synchronized levels.
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic sda_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   // Chains reset to 1 so an idle bus never looks like an edge after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s       = scl_sync_q[SYNC_STAGES-1];
   assign sda_s       = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise_o  = scl_s & ~scl_prev_q;
   assign scl_fall_o  = ~scl_s & scl_prev_q;
   assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign sda_o       = sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C write-only register slave: accepts START, {addr,W}, sub-address, data,
// STOP and presents the completed write as a one-cycle REG_WE strobe.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic [7:0] REG_ADDR,
   output logic [7:0] REG_DATA,
   output logic       REG_WE,
   output logic       BUSY,
   output logic       ERR,
   output i2c_state_e DBG_STATE
);

   logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
   i2c_state_e state_q;
   logic [3:0] bit_cnt_q;
   logic [7:0] addr_sr_q, sub_sr_q, data_sr_q;
   logic [7:0] reg_addr_q, reg_data_q;
   logic       sda_oe_q, reg_we_q, busy_q, err_q;
   logic       open_q;       // addressed write frame in progress, REG_WE not yet issued
   logic       done_q;       // write completed in this frame
   logic       extra_err_q;  // ERR already raised for trailing bytes
   logic       byte_full;

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
      .clk_i       (CLOCK),
      .rst_i       (RESET),
      .scl_i       (I2C_SCLK),
      .sda_i       (I2C_SDAT),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_det_o (start_det),
      .stop_det_o  (stop_det),
      .sda_o       (sda_s)
   );

   assign byte_full = (bit_cnt_q == 4'd8);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         addr_sr_q   <= '0;
         sub_sr_q    <= '0;
         data_sr_q   <= '0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
         sda_oe_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         open_q      <= 1'b0;
         done_q      <= 1'b0;
         extra_err_q <= 1'b0;
      end else begin
         reg_we_q <= 1'b0;
         err_q    <= 1'b0;
         if (stop_det) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            sda_oe_q <= 1'b0;
            err_q    <= open_q;
            open_q   <= 1'b0;
            done_q   <= 1'b0;
         end else if (start_det) begin
            state_q     <= ST_ADDR;
            bit_cnt_q   <= '0;
            sda_oe_q    <= 1'b0;
            err_q       <= open_q;
            open_q      <= 1'b0;
            done_q      <= 1'b0;
            extra_err_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
               end
               ST_ADDR, ST_SUB, ST_DATA, ST_WAIT_STOP: begin
                  if (scl_rise && !byte_full) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (state_q == ST_ADDR) addr_sr_q <= {addr_sr_q[6:0], sda_s};
                     if (state_q == ST_SUB)  sub_sr_q  <= {sub_sr_q[6:0], sda_s};
                     if (state_q == ST_DATA) data_sr_q <= {data_sr_q[6:0], sda_s};
                  end else if (scl_fall && byte_full) begin
                     bit_cnt_q <= '0;
                     if (state_q == ST_ADDR) begin
                        if (addr_sr_q[7:1] != SLAVE_ADDR) begin
                           state_q <= ST_WAIT_STOP;
                           busy_q  <= 1'b0;
                        end else if (addr_sr_q[0] == I2C_WRITE) begin
                           state_q  <= ST_ACK_ADDR;
                           sda_oe_q <= 1'b1;
                           busy_q   <= 1'b1;
                           open_q   <= 1'b1;
                        end else begin
                           state_q <= ST_WAIT_STOP;
                           busy_q  <= 1'b0;
                           err_q   <= 1'b1;
                        end
                     end else if (state_q == ST_SUB) begin
                        state_q  <= ST_ACK_SUB;
                        sda_oe_q <= 1'b1;
                     end else if (state_q == ST_DATA) begin
                        state_q  <= ST_ACK_DATA;
                        sda_oe_q <= 1'b1;
                     end else if (done_q && !extra_err_q) begin
                        err_q       <= 1'b1;
                        extra_err_q <= 1'b1;
                     end
                  end
               end
               ST_ACK_ADDR, ST_ACK_SUB, ST_ACK_DATA: begin
                  if (scl_fall) begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= '0;
                     if (state_q == ST_ACK_ADDR) state_q <= ST_SUB;
                     if (state_q == ST_ACK_SUB)  state_q <= ST_DATA;
                     if (state_q == ST_ACK_DATA) begin
                        state_q    <= ST_WAIT_STOP;
                        reg_addr_q <= sub_sr_q;
                        reg_data_q <= data_sr_q;
                        reg_we_q   <= 1'b1;
                        open_q     <= 1'b0;
                        done_q     <= 1'b1;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Open-drain: only ever pull low, otherwise release.
   assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
   assign REG_ADDR  = reg_addr_q;
   assign REG_DATA  = reg_data_q;
   assign REG_WE    = reg_we_q;
   assign BUSY      = busy_q;
   assign ERR       = err_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master tasks, bus monitor
// counters and per-scenario tasks with hand-computed expectations.
module tb_i2c_reg_slave;
   import i2c_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_low;
   wire        sda_bus;
   logic [7:0] reg_addr, reg_data;
   logic       reg_we, busy, err;
   i2c_state_e dbg_state;

   int n_vec = 0;
   int n_err = 0;

   int         we_cnt = 0, err_cnt = 0, drv_cnt = 0, busy_cnt = 0;
   logic [7:0] we_addr = 8'h00, we_data = 8'h00;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_reg_slave #(.SLAVE_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
      .CLOCK     (clk),
      .RESET     (rst),
      .I2C_SCLK  (scl),
      .I2C_SDAT  (sda_bus),
      .REG_ADDR  (reg_addr),
      .REG_DATA  (reg_data),
      .REG_WE    (reg_we),
      .BUSY      (busy),
      .ERR       (err),
      .DBG_STATE (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // bus activity counters, sampled away from the active edge
   always @(negedge clk) begin
      if (reg_we === 1'b1) begin
         we_cnt  = we_cnt + 1;
         we_addr = reg_addr;
         we_data = reg_data;
      end
      if (err === 1'b1) err_cnt = err_cnt + 1;
      if (!sda_low && sda_bus === 1'b0) drv_cnt = drv_cnt + 1;
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
   end

   // driver tasks (SCL quarter period = 40, i.e. 4 CLOCKs)
   task automatic bus_start();
      sda_low = 1'b0; #40;
      scl     = 1'b1; #40;
      sda_low = 1'b1; #40;
      scl     = 1'b0; #40;
   endtask

   task automatic bus_stop();
      sda_low = 1'b1; #40;
      scl     = 1'b1; #40;
      sda_low = 1'b0; #40;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_low = ~b[i]; #40;
         scl     = 1'b1;  #80;
         scl     = 1'b0;  #40;
      end
   endtask

   task automatic ack_clock(output logic ack);
      sda_low = 1'b0; #40;
      scl     = 1'b1; #40;
      ack     = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      #40;
      scl     = 1'b0; #40;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      ack_clock(ack);
   endtask

   task automatic pulse_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      pulse_reset(3);
      n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); end
      n_vec++; if (reg_data !== 8'h00) begin n_err++; $display("FAIL reset_reg_data: got %h expected 00", reg_data); end
      n_vec++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL reset_reg_we: got %b expected 0", reg_we); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      n_vec++; if (sda_bus !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b expected 1", sda_bus); end
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, a0);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy_after_addr: got %b expected 1", busy); end
      send_byte(8'h0E, a1);
      send_byte(8'h4A, a2);
      n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy_before_stop: got %b expected 1", busy); end
      n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL write_we_count: got %0d expected 1", we_cnt - we0); end
      n_vec++; if (we_addr !== 8'h0E || we_data !== 8'h4A) begin n_err++; $display("FAIL write_we_payload: got %h/%h expected 0e/4a", we_addr, we_data); end
      bus_stop();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
      n_vec++; if (err_cnt - err0 !== 0) begin n_err++; $display("FAIL write_err_count: got %0d expected 0", err_cnt - err0); end
      n_vec++; if (reg_addr !== 8'h0E || reg_data !== 8'h4A) begin n_err++; $display("FAIL write_regs: got %h/%h expected 0e/4a", reg_addr, reg_data); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL write_state_after_stop: got %0d expected %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1, a2;
      int we0, err0, drv0, busy0;
      we0 = we_cnt; err0 = err_cnt; drv0 = drv_cnt; busy0 = busy_cnt;
      bus_start();
      send_byte(8'h36, a0);
      send_byte(8'hAA, a1);
      send_byte(8'h55, a2);
      bus_stop();
      n_vec++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL mismatch_acks: got %b expected 111", {a0, a1, a2}); end
      n_vec++; if (drv_cnt - drv0 !== 0) begin n_err++; $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", drv_cnt - drv0); end
      n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL mismatch_we_count: got %0d expected 0", we_cnt - we0); end
      n_vec++; if (err_cnt - err0 !== 0) begin n_err++; $display("FAIL mismatch_err_count: got %0d expected 0", err_cnt - err0); end
      n_vec++; if (busy_cnt - busy0 !== 0) begin n_err++; $display("FAIL mismatch_busy_cycles: got %0d expected 0", busy_cnt - busy0); end
   endtask

   task automatic test_read_reject();
      logic a0;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h35, a0);
      n_vec++; if (a0 !== 1'b1) begin n_err++; $display("FAIL read_ack: got %b expected 1", a0); end
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL read_err_at_addr: got %0d expected 1", err_cnt - err0); end
      bus_stop();
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL read_err_total: got %0d expected 1", err_cnt - err0); end
      n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL read_we_count: got %0d expected 0", we_cnt - we0); end
   endtask

   task automatic test_early_stop();
      logic a0, a1;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, a0);
      send_byte(8'h10, a1);
      bus_stop();
      n_vec++; if ({a0, a1} !== 2'b00) begin n_err++; $display("FAIL early_stop_acks: got %b expected 00", {a0, a1}); end
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL early_stop_err_count: got %0d expected 1", err_cnt - err0); end
      n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL early_stop_we_count: got %0d expected 0", we_cnt - we0); end
      n_vec++; if (reg_addr !== 8'h0E || reg_data !== 8'h4A) begin n_err++; $display("FAIL early_stop_regs_kept: got %h/%h expected 0e/4a", reg_addr, reg_data); end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2, a3, a4;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, a0);
      send_byte(8'h05, a1);
      bus_start();
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL rstart_err_at_restart: got %0d expected 1", err_cnt - err0); end
      n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL rstart_we_before_frame: got %0d expected 0", we_cnt - we0); end
      send_byte(8'h34, a2);
      send_byte(8'h07, a3);
      send_byte(8'h99, a4);
      bus_stop();
      n_vec++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin n_err++; $display("FAIL rstart_acks: got %b expected 00000", {a0, a1, a2, a3, a4}); end
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL rstart_err_total: got %0d expected 1", err_cnt - err0); end
      n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL rstart_we_count: got %0d expected 1", we_cnt - we0); end
      n_vec++; if (reg_addr !== 8'h07 || reg_data !== 8'h99) begin n_err++; $display("FAIL rstart_regs: got %h/%h expected 07/99", reg_addr, reg_data); end
   endtask

   task automatic test_back_to_back_extra();
      logic a0, a1, a2, a3, a4;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, a0);
      send_byte(8'h21, a1);
      send_byte(8'h3C, a2);
      send_byte(8'hFF, a3);
      send_byte(8'h00, a4);
      bus_stop();
      n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL extra_frame_acks: got %b expected 000", {a0, a1, a2}); end
      n_vec++; if ({a3, a4} !== 2'b11) begin n_err++; $display("FAIL extra_byte_nacks: got %b expected 11", {a3, a4}); end
      n_vec++; if (err_cnt - err0 !== 1) begin n_err++; $display("FAIL extra_err_count: got %0d expected 1", err_cnt - err0); end
      n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL extra_we_count: got %0d expected 1", we_cnt - we0); end
      n_vec++; if (reg_addr !== 8'h21 || reg_data !== 8'h3C) begin n_err++; $display("FAIL extra_regs: got %h/%h expected 21/3c", reg_addr, reg_data); end
   endtask

   task automatic test_reset_mid_frame();
      logic a0, a1, a2, b0, b1, b2;
      int we0, err0;
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, a0);
      send_byte(8'h0E, a1);
      send_bits(8'h4A, 4);
      pulse_reset(1);
      n_vec++; if (reg_addr !== 8'h00 || reg_data !== 8'h00) begin n_err++; $display("FAIL midrst_regs: got %h/%h expected 00/00", reg_addr, reg_data); end
      n_vec++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_busy_state: got %b/%0d expected 0/%0d", busy, dbg_state, ST_IDLE); end
      send_bits(8'hA0, 4);
      ack_clock(a2);
      bus_stop();
      n_vec++; if ({a0, a1, a2} !== 3'b001) begin n_err++; $display("FAIL midrst_acks: got %b expected 001", {a0, a1, a2}); end
      n_vec++; if (we_cnt - we0 !== 0 || err_cnt - err0 !== 0) begin n_err++; $display("FAIL midrst_we_err: got %0d/%0d expected 0/0", we_cnt - we0, err_cnt - err0); end
      we0 = we_cnt; err0 = err_cnt;
      bus_start();
      send_byte(8'h34, b0);
      send_byte(8'h5A, b1);
      send_byte(8'hC3, b2);
      bus_stop();
      n_vec++; if ({b0, b1, b2} !== 3'b000) begin n_err++; $display("FAIL midrst_next_acks: got %b expected 000", {b0, b1, b2}); end
      n_vec++; if (we_cnt - we0 !== 1 || err_cnt - err0 !== 0) begin n_err++; $display("FAIL midrst_next_we_err: got %0d/%0d expected 1/0", we_cnt - we0, err_cnt - err0); end
      n_vec++; if (reg_addr !== 8'h5A || reg_data !== 8'hC3) begin n_err++; $display("FAIL midrst_next_regs: got %h/%h expected 5a/c3", reg_addr, reg_data); end
   endtask

   initial begin
      rst     = 1'b1;
      scl     = 1'b1;
      sda_low = 1'b0;
      test_reset();
      test_write();
      test_addr_mismatch();
      test_read_reject();
      test_early_stop();
      test_repeated_start();
      test_back_to_back_extra();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
